// File: rtl/hub75_rx_if.sv
// HUB75 panel bus plus readback and status signals for the receive-side capture block.
// Handshake: the HUB75 bus has no valid/ready pair. hub_clk rising edges
// qualify hub_rgb0/hub_rgb1, hub_latch rising edges qualify hub_row, and the
// status pulses (row_valid, frame_done) last one clk cycle and cannot be
// back-pressured.
interface hub75_rx_if;
    logic       hub_clk;
    logic       hub_latch;
    logic       hub_oe;
    logic [3:0] hub_row;
    logic [2:0] hub_rgb0;
    logic [2:0] hub_rgb1;
    logic [4:0] rd_row;
    logic [4:0] rd_col;
    logic [2:0] rd_rgb;
    logic       row_valid;
    logic [3:0] row_addr;
    logic       lit;
    logic       frame_done;
    logic       err_overflow;
    logic       err_short;

    // Panel driver / bench side.
    modport master (
        output hub_clk, hub_latch, hub_oe, hub_row, hub_rgb0, hub_rgb1, rd_row, rd_col,
        input  rd_rgb, row_valid, row_addr, lit, frame_done, err_overflow, err_short
    );

    // Capture block side.
    modport slave (
        input  hub_clk, hub_latch, hub_oe, hub_row, hub_rgb0, hub_rgb1, rd_row, rd_col,
        output rd_rgb, row_valid, row_addr, lit, frame_done, err_overflow, err_short
    );
endinterface

// File: rtl/hub75_rx.sv
// HUB75 receive capture. It oversamples the panel bus, deserializes each row
// shift, and commits it into a 32x32 RGB frame buffer when the latch rises.
module hub75_rx #(
    parameter int COLS      = 32,
    parameter int HALF_ROWS = 16
) (
    input  logic       clk,
    input  logic       reset,
    hub75_rx_if.slave  bus
);
    localparam int          SW     = 3 * COLS;
    localparam int          IW     = $clog2(SW);
    localparam logic [5:0]  COLS_C = 6'(COLS);

    // Synchronizer stages. Stage 3 exists only for edge detection.
    logic           r_clk_s1, r_clk_s2, r_clk_s3;
    logic           r_lat_s1, r_lat_s2, r_lat_s3;
    logic           r_oe_s1, r_oe_s2;
    logic [3:0]     r_row_s1, r_row_s2;
    logic [2:0]     r_rgb0_s1, r_rgb0_s2;
    logic [2:0]     r_rgb1_s1, r_rgb1_s2;

    logic [SW-1:0]  r_sh0, r_sh1;
    logic [5:0]     r_col_cnt;
    logic           r_err_ovf, r_err_short;
    logic           r_row_valid, r_frame_done, r_have_row;
    logic [3:0]     r_row_addr;
    logic           r_lit;
    logic [2:0]     r_rd_rgb;
    logic [SW-1:0]  r_fb_top [HALF_ROWS];
    logic [SW-1:0]  r_fb_bot [HALF_ROWS];

    logic           w_clk_rise, w_lat_rise, w_shift_ok;
    logic [IW-1:0]  w_wr_idx, w_rd_idx;
    logic [SW-1:0]  w_sh0_next, w_sh1_next, w_rd_line;
    logic [5:0]     w_cnt_next;

    // Two-stage synchronizers plus a third stage for edge detection; hub_oe preloads high so lit starts low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_clk_s1  <= 1'b0; r_clk_s2 <= 1'b0; r_clk_s3 <= 1'b0;
            r_lat_s1  <= 1'b0; r_lat_s2 <= 1'b0; r_lat_s3 <= 1'b0;
            r_oe_s1   <= 1'b1; r_oe_s2  <= 1'b1;
            r_row_s1  <= '0;   r_row_s2 <= '0;
            r_rgb0_s1 <= '0;   r_rgb0_s2 <= '0;
            r_rgb1_s1 <= '0;   r_rgb1_s2 <= '0;
        end else begin
            r_clk_s1  <= bus.hub_clk;   r_clk_s2  <= r_clk_s1;  r_clk_s3 <= r_clk_s2;
            r_lat_s1  <= bus.hub_latch; r_lat_s2  <= r_lat_s1;  r_lat_s3 <= r_lat_s2;
            r_oe_s1   <= bus.hub_oe;    r_oe_s2   <= r_oe_s1;
            r_row_s1  <= bus.hub_row;   r_row_s2  <= r_row_s1;
            r_rgb0_s1 <= bus.hub_rgb0;  r_rgb0_s2 <= r_rgb0_s1;
            r_rgb1_s1 <= bus.hub_rgb1;  r_rgb1_s2 <= r_rgb1_s1;
        end
    end

    // Next shift-register image; a shift in the same cycle as a latch is applied before the commit sees it.
    always_comb begin
        w_clk_rise = r_clk_s2 & ~r_clk_s3;
        w_lat_rise = r_lat_s2 & ~r_lat_s3;
        w_shift_ok = w_clk_rise && (r_col_cnt < COLS_C);
        w_wr_idx   = IW'(r_col_cnt) * IW'(3);
        w_sh0_next = r_sh0;
        w_sh1_next = r_sh1;
        w_cnt_next = r_col_cnt;
        if (w_shift_ok) begin
            w_sh0_next[w_wr_idx +: 3] = r_rgb0_s2;
            w_sh1_next[w_wr_idx +: 3] = r_rgb1_s2;
            w_cnt_next                = r_col_cnt + 6'd1;
        end
    end

    // Shift capture, commit bookkeeping, wrap detection and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sh0        <= '0;
            r_sh1        <= '0;
            r_col_cnt    <= '0;
            r_err_ovf    <= 1'b0;
            r_err_short  <= 1'b0;
            r_row_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_have_row   <= 1'b0;
            r_row_addr   <= '0;
            r_lit        <= 1'b0;
        end else begin
            r_row_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_lit        <= ~r_oe_s2;
            r_sh0        <= w_sh0_next;
            r_sh1        <= w_sh1_next;
            if (w_clk_rise && !w_shift_ok) begin
                r_err_ovf <= 1'b1;
            end
            if (w_lat_rise) begin
                r_col_cnt    <= '0;
                r_row_addr   <= r_row_s2;
                r_row_valid  <= 1'b1;
                r_have_row   <= 1'b1;
                // The driver rescans from row 0, so a non-increasing row ends a frame.
                r_frame_done <= r_have_row && (r_row_s2 <= r_row_addr);
                if (w_cnt_next != COLS_C) begin
                    r_err_short <= 1'b1;
                end
            end else begin
                r_col_cnt <= w_cnt_next;
            end
        end
    end

    // Frame buffer write on latch commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < HALF_ROWS; i++) begin
                r_fb_top[i] <= '0;
                r_fb_bot[i] <= '0;
            end
        end else if (w_lat_rise) begin
            r_fb_top[r_row_s2] <= w_sh0_next;
            r_fb_bot[r_row_s2] <= w_sh1_next;
        end
    end

    always_comb begin
        w_rd_line = bus.rd_row[4] ? r_fb_bot[bus.rd_row[3:0]] : r_fb_top[bus.rd_row[3:0]];
        w_rd_idx  = IW'(bus.rd_col) * IW'(3);
    end

    // Registered readback; a same-cycle commit is not visible until the next read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_rgb <= '0;
        end else begin
            r_rd_rgb <= w_rd_line[w_rd_idx +: 3];
        end
    end

    assign bus.rd_rgb       = r_rd_rgb;
    assign bus.row_valid    = r_row_valid;
    assign bus.row_addr     = r_row_addr;
    assign bus.lit          = r_lit;
    assign bus.frame_done   = r_frame_done;
    assign bus.err_overflow = r_err_ovf;
    assign bus.err_short    = r_err_short;
endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: directed steps with random pixel data, scored against a pixel-level frame model.
module tb_hub75_rx;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hub75_rx_if bus();

    hub75_rx #(.COLS(32), .HALF_ROWS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pixel arrays indexed by row and column.
    logic [2:0] m_top [16][32];
    logic [2:0] m_bot [16][32];
    logic [2:0] m_sh0 [32];
    logic [2:0] m_sh1 [32];
    int         m_cnt;
    bit         m_ovf, m_short, m_have, m_oe;
    logic [3:0] m_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) begin
                m_top[r][c] = '0;
                m_bot[r][c] = '0;
            end
        for (int c = 0; c < 32; c++) begin
            m_sh0[c] = '0;
            m_sh1[c] = '0;
        end
        m_cnt = 0; m_ovf = 0; m_short = 0; m_have = 0; m_last = '0;
    endtask

    task automatic model_shift(input logic [2:0] a, input logic [2:0] b);
        if (m_cnt < 32) begin
            m_sh0[m_cnt] = a;
            m_sh1[m_cnt] = b;
            m_cnt++;
        end else begin
            m_ovf = 1;
        end
    endtask

    task automatic model_commit(input logic [3:0] row, output logic exp_fd);
        exp_fd = m_have && (row <= m_last);
        for (int c = 0; c < 32; c++) begin
            m_top[row][c] = m_sh0[c];
            m_bot[row][c] = m_sh1[c];
        end
        if (m_cnt != 32) m_short = 1;
        m_cnt  = 0;
        m_last = row;
        m_have = 1;
    endtask

    // Driver: one hub_clk and/or hub_latch pulse, 4+ cycles per phase.
    task automatic pulse(input bit do_clk, input bit do_lat, input logic [2:0] a,
                         input logic [2:0] b, input logic [3:0] row);
        int   k;
        logic exp_fd;
        bus.hub_rgb0 = a;
        bus.hub_rgb1 = b;
        bus.hub_row  = row;
        repeat (4) @(negedge clk);
        exp_fd = 1'b0;
        if (do_clk) model_shift(a, b);
        if (do_lat) model_commit(row, exp_fd);
        bus.hub_clk   = do_clk;
        bus.hub_latch = do_lat;
        if (do_lat) begin
            k = 0;
            while (k < 8 && bus.row_valid !== 1'b1) begin
                @(negedge clk);
                k++;
            end
            check("row_valid_latency", k, 3);
            check("row_addr", {28'd0, bus.row_addr}, {28'd0, row});
            check("frame_done", {31'd0, bus.frame_done}, {31'd0, exp_fd});
            @(negedge clk);
            check("row_valid_pulse", {31'd0, bus.row_valid}, 0);
            check("frame_done_pulse", {31'd0, bus.frame_done}, 0);
            @(negedge clk);
        end else begin
            repeat (4) @(negedge clk);
        end
        bus.hub_clk   = 1'b0;
        bus.hub_latch = 1'b0;
        @(negedge clk);
        check("err_overflow", {31'd0, bus.err_overflow}, {31'd0, m_ovf});
        check("err_short", {31'd0, bus.err_short}, {31'd0, m_short});
    endtask

    task automatic shift_px(input logic [2:0] a, input logic [2:0] b);
        pulse(1'b1, 1'b0, a, b, bus.hub_row);
    endtask

    task automatic latch_row(input logic [3:0] row);
        pulse(1'b0, 1'b1, bus.hub_rgb0, bus.hub_rgb1, row);
    endtask

    task automatic random_row(input int len, input logic [3:0] row);
        for (int i = 0; i < len; i++)
            shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        latch_row(row);
    endtask

    // Scoreboard readback of one pixel.
    task automatic read_check(input int r, input int c);
        logic [2:0] exp;
        bus.rd_row = 5'(r);
        bus.rd_col = 5'(c);
        @(negedge clk);
        exp = (r >= 16) ? m_bot[r - 16][c] : m_top[r][c];
        check($sformatf("rd_rgb(%0d,%0d)", r, c), {29'd0, bus.rd_rgb}, {29'd0, exp});
    endtask

    task automatic frame_check();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                read_check(r, c);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        m_oe          = 1;
        reset         = 1'b0;
        bus.hub_clk   = 1'b0;
        bus.hub_latch = 1'b0;
        bus.hub_oe    = 1'b1;
        bus.hub_row   = '0;
        bus.hub_rgb0  = '0;
        bus.hub_rgb1  = '0;
        bus.rd_row    = '0;
        bus.rd_col    = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_row_valid", {31'd0, bus.row_valid}, 0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 0);
        check("rst_row_addr", {28'd0, bus.row_addr}, 0);
        check("rst_lit", {31'd0, bus.lit}, 0);
        check("rst_err_overflow", {31'd0, bus.err_overflow}, 0);
        check("rst_err_short", {31'd0, bus.err_short}, 0);
        check("rst_rd_rgb", {29'd0, bus.rd_rgb}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // lit follows inverted hub_oe.
        bus.hub_oe = 1'b0; m_oe = 0;
        repeat (4) @(negedge clk);
        check("lit_on", {31'd0, bus.lit}, 1);
        bus.hub_oe = 1'b1; m_oe = 1;
        repeat (4) @(negedge clk);
        check("lit_off", {31'd0, bus.lit}, 0);
        bus.hub_oe = 1'b0; m_oe = 0;

        // Full row: constant colours into row 5.
        for (int c = 0; c < 32; c++) shift_px(3'b001, 3'b100);
        latch_row(4'd5);
        frame_check();

        // Column order: rgb0 carries the column number.
        for (int c = 0; c < 32; c++) shift_px(3'(c), 3'($urandom_range(0, 7)));
        latch_row(4'd0);
        read_check(0, 9);
        read_check(0, 31);
        check("col_order_9", {29'd0, m_top[0][9]}, 1);
        check("col_order_31", {29'd0, m_top[0][31]}, 7);

        // Overflow: 33rd sample is discarded.
        for (int c = 0; c < 32; c++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        shift_px(3'b111, 3'($urandom_range(0, 7)));
        latch_row(4'($urandom_range(0, 15)));
        for (int c = 0; c < 32; c++) read_check(int'(m_last), c);

        // Short row, then a valid row; err_short stays set.
        random_row(10, 4'd3);
        for (int c = 0; c < 32; c++) read_check(3, c);
        random_row(32, 4'd7);
        frame_check();

        // Reset mid-shift, asserted between clock edges.
        for (int i = 0; i < 17; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("async_err_overflow", {31'd0, bus.err_overflow}, 0);
        check("async_err_short", {31'd0, bus.err_short}, 0);
        check("async_row_addr", {28'd0, bus.row_addr}, 0);
        check("async_lit", {31'd0, bus.lit}, 0);
        check("async_rd_rgb", {29'd0, bus.rd_rgb}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("lit_after_reset", {31'd0, bus.lit}, {31'd0, !m_oe});

        // Frame wrap: rows 0, 1, 2, 0 after reset; only the last wraps.
        random_row(32, 4'd0);
        frame_check();
        random_row(32, 4'd1);
        random_row(32, 4'd2);
        random_row(32, 4'd0);

        // Simultaneous hub_clk and hub_latch after 31 shifts completes the row.
        for (int i = 0; i < 31; i++) shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        pulse(1'b1, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'd9);
        for (int c = 0; c < 32; c++) read_check(9, c);
        for (int c = 0; c < 32; c++) read_check(25, c);

        // Random rows of mixed length and address.
        for (int n = 0; n < 8; n++) begin
            int         len;
            logic [3:0] row;
            case ($urandom_range(0, 3))
                0:       len = $urandom_range(1, 31);
                1:       len = $urandom_range(33, 35);
                default: len = 32;
            endcase
            row = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < len - 1; i++)
                    shift_px(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                pulse(1'b1, 1'b1, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), row);
            end else begin
                random_row(len, row);
            end
        end
        frame_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hub75_rx.md
# hub75_rx

Receive-side HUB75 capture block for the 32x32 crane-game panel. It runs on the 12 MHz fabric clock and oversamples the panel bus: serial RGB clock, latch, output-enable, 4-bit row address and the two RGB triplets. It deserializes each 32-column shift into a row image and commits it to an internal 32x32 RGB frame buffer on latch. Readback, frame-wrap and protocol-error flags support loopback self-test of the matrix driver and bench scoring.

## Interface
Parameters
- COLS, 32, columns per row shift; shift registers are 3*COLS bits wide.
- HALF_ROWS, 16, rows per panel half; this is also the row-address range.

Ports
- clk  in  1  12 MHz fabric clock.
- reset  in  1  asynchronous, active-low; clears all state.
- hub_clk  in  1  serial RGB shift clock from the driver; data is valid on its rising edge.
- hub_latch  in  1  row latch; its rising edge commits the shifted row.
- hub_oe  in  1  output enable, active-low.
- hub_row  in  4  row address presented with the latch.
- hub_rgb0  in  3  top-half pixel bits {B,G,R} = [2:0].
- hub_rgb1  in  3  bottom-half pixel bits.
- rd_row  in  5  readback row: 0-15 is top half, 16-31 is bottom half.
- rd_col  in  5  readback column.
- rd_rgb  out  3  frame-buffer pixel at (rd_row, rd_col); registered.
- row_valid  out  1  one-cycle pulse when a row is committed.
- row_addr  out  4  address of the last committed row.
- lit  out  1  synced inverse of hub_oe; high while the panel is displaying.
- frame_done  out  1  one-cycle pulse on row-address wrap.
- err_overflow  out  1  sticky; set when a row shift exceeds COLS.
- err_short  out  1  sticky; set when a latch arrives with fewer than COLS shifts.

## Operation
- **Input sync.** All hub_* inputs pass through 2-FF synchronizers. Rising edges of hub_clk and hub_latch are detected from the last two synced samples. RGB is sampled from the same synced stage as hub_clk.
- **Shift capture.** col_cnt (6 bits) starts at 0.
  - On a hub_clk rise with col_cnt < COLS: sh0[3*col_cnt +: 3] <= rgb0, sh1[3*col_cnt +: 3] <= rgb1, col_cnt++.
  - On a hub_clk rise with col_cnt == COLS: sample discarded, err_overflow set, col_cnt held.
- **Latch commit.** On a hub_latch rise:
  - fb_top[hub_row] <= sh0 and fb_bot[hub_row] <= sh1.
  - row_addr <= hub_row; row_valid pulses; col_cnt <= 0.
  - If col_cnt != COLS, err_short is set; the data is still committed (unshifted columns keep their previous shift-register contents).
- **Simultaneous events.** If a hub_clk rise and a hub_latch rise are detected in the same cycle, the shift is applied first and the commit includes the new pixel. col_cnt is checked after the increment.
- **Frame wrap.** frame_done pulses on a commit whose hub_row <= the previous committed row_addr. The first commit after reset never pulses frame_done. Repeated latches of the same row count as a wrap, because the driver rescans from row 0 up to a variable limit.
- **Readback.** rd_rgb <= (rd_row[4] ? fb_bot : fb_top)[rd_row[3:0]][3*rd_col +: 3].
- **Reset.** Applies asynchronously at any time, including mid-shift:
  - frame buffer, shift registers, col_cnt, row_addr, rd_rgb, error flags and synchronizers go to 0;
  - row_valid and frame_done go to 0;
  - lit goes to 0 (synchronizer preloaded to hub_oe = 1).
  - The first edge after release is detected only from post-reset samples.
- **Error flags.** They are sticky and clear only on reset.

## Timing
- **Input capture latency.** Pixel capture, lit and edge detection occur 3 clk cycles after the input transition (2 sync stages + edge register).
- **Commit latency.** row_valid, row_addr and the frame-buffer write occur 3 cycles after hub_latch rises. frame_done coincides with row_valid.
- **Readback latency.** rd_rgb reflects rd_row/rd_col 1 cycle after they are applied. A read of a row committed in the same cycle returns the old data.
- **Input requirements.** hub_clk high and low phases must each be ≥ 2 clk cycles; the driver runs at 1.5 MHz, i.e. 4 cycles per phase. RGB and hub_row must be stable ≥ 2 cycles before and 1 cycle after the relevant edge.
- **Outputs.** All are registered; there are no combinational input-to-output paths.

## Test plan
- **Full row.** 32 hub_clk pulses with rgb0 = 3'b001 and rgb1 = 3'b100, then latch with hub_row = 5 -> row_valid pulse, row_addr = 5; reads of (5, c) give 001 and (21, c) give 100 for all c; no error flags.
- **Column order.** rgb0 = col[2:0] for cols 0-31, latch row 0 -> rd (0, 9) = 3'b001, rd (0, 31) = 3'b111.
- **Overflow.** 33 shifts with the 33rd rgb0 = 111, then latch -> err_overflow = 1; col 31 holds the 32nd value; err_short = 0.
- **Short row and sticky flag.** 10 shifts then latch -> err_short = 1; cols 10-31 keep prior data; err_short stays 1 after a following valid row.
- **Frame wrap and simultaneous events.** Commit rows 0, 1, 2, 0 -> frame_done pulses only on the 4th commit. A hub_clk and hub_latch rise in the same cycle after 31 shifts -> err_short = 0.
- **Reset mid-shift.** Assert reset after 17 shifts, release, then perform a full row and latch -> clean commit; col_cnt restarts at 0; flags 0; rd of any other row returns 000.
